// File: rtl/csa_mult_ctrl.sv
// Sequential carry-save multiplier controller driving an external N-bit full-adder bank.
// Optional CSA_MULT_EARLY_EXIT_EN ends the carry-resolve phase once the carry vector clears.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; adder bank inputs held at zero
// ACCUM   | N carry-save accumulate/shift steps; low product bits shift out
// RESOLVE | ripple remaining carries of the high half through the bank
// DONE    | product registered, one-cycle done pulse
module csa_mult_ctrl #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   op_a,
   input  logic [N-1:0]   op_b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product,
   output logic [N-1:0]   fa_a,
   output logic [N-1:0]   fa_b,
   output logic [N-1:0]   fa_c,
   input  logic [N-1:0]   fa_sum,
   input  logic [N-1:0]   fa_cout
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     s_q, s_d;
   logic [N-1:0]     c_q, c_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [N-1:0]     plo_q, plo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*N-1:0]   prod_q, prod_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         c_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         plo_q   <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         c_q     <= c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         plo_q   <= plo_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   logic [N-1:0] res_c;
   logic         early_exit;

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      c_d        = c_q;
      a_d        = a_q;
      b_d        = b_q;
      plo_d      = plo_q;
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      fa_a       = '0;
      fa_b       = '0;
      fa_c       = '0;
      // Top carry bit is dropped: the high half of the product always fits in N bits.
      res_c      = {fa_cout[N-2:0], 1'b0};
`ifdef CSA_MULT_EARLY_EXIT_EN
      early_exit = (res_c == '0);
`else
      early_exit = 1'b0;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACCUM;
               a_d     = op_a;
               b_d     = op_b;
               s_d     = '0;
               c_d     = '0;
               plo_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_ACCUM: begin
            fa_a  = s_q;
            fa_b  = c_q;
            fa_c  = a_q & {N{b_q[0]}};
            s_d   = {1'b0, fa_sum[N-1:1]};
            c_d   = fa_cout;
            plo_d = {fa_sum[0], plo_q[N-1:1]};
            b_d   = b_q >> 1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_RESOLVE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RESOLVE: begin
            fa_a  = s_q;
            fa_b  = c_q;
            s_d   = fa_sum;
            c_d   = res_c;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST || early_exit) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               prod_d  = {fa_sum, plo_q};
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign product = prod_q;

endmodule

// File: tb/tb_csa_mult_ctrl.sv
// Scoreboard bench for csa_mult_ctrl (N=8) with a behavioural full-adder bank.
module tb_csa_mult_ctrl;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [N-1:0]   op_a = '0;
   logic [N-1:0]   op_b = '0;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;
   logic [N-1:0]   fa_a, fa_b, fa_c, fa_sum, fa_cout;

   csa_mult_ctrl #(.N(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op_a    (op_a),
      .op_b    (op_b),
      .busy    (busy),
      .done    (done),
      .product (product),
      .fa_a    (fa_a),
      .fa_b    (fa_b),
      .fa_c    (fa_c),
      .fa_sum  (fa_sum),
      .fa_cout (fa_cout)
   );

   // external full-adder bank
   assign fa_sum  = fa_a ^ fa_b ^ fa_c;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   typedef struct {
      logic [2*N-1:0] prod;
      int             lo;
      int             hi;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int done_exp = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // monitor: pops an expectation for every done pulse
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done actual=%0h required=no_done", product);
         end else begin
            mon_e = sb.pop_front();
            if (product !== mon_e.prod) begin
               failures++;
               $display("FAIL product actual=%0h required=%0h", product, mon_e.prod);
            end
            checks++;
            if (ecnt < mon_e.lo || ecnt > mon_e.hi) begin
               failures++;
               $display("FAIL done_latency actual_edge=%0d required=%0d..%0d", ecnt, mon_e.lo, mon_e.hi);
            end
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL busy_in_done actual=%0b required=1", busy);
            end
         end
      end
   end

   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, output int k);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      k     = ecnt + 1;
      e.prod = (2*N)'(a) * (2*N)'(b);
`ifdef CSA_MULT_EARLY_EXIT_EN
      e.lo = k + N + 1;
      e.hi = (a == 0 || b == 0) ? k + N + 1 : k + 2*N;
`else
      e.lo = k + 2*N;
      e.hi = k + 2*N;
`endif
      sb.push_back(e);
      done_exp++;
      @(negedge clk);
      start = 1'b0;
      op_a  = N'($urandom);
      op_b  = N'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      int k;
      issue(a, b, k);
      wait_idle();
   endtask

   initial begin
      int k;
      int n;
      int dc;
      logic ok;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_product", product, 0);
      chk("rst_fa_a", fa_a, 0);
      chk("rst_fa_b", fa_b, 0);
      chk("rst_fa_c", fa_c, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 0xFF*0xFF with ignored starts while busy and during DONE
      dc = done_cnt;
      issue(8'hFF, 8'hFF, k);
      @(negedge clk);
      start = 1'b1; op_a = 8'h01; op_b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen_ff", done, 1);
      start = 1'b1; op_a = 8'h01; op_b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      chk("ignored_start_in_done", busy, 0);
      repeat (2*N + 4) @(negedge clk);
      chk("single_done_pulse", done_cnt - dc, 1);
      chk("product_held_ff", product, 16'hFE01);

      // 13*11 and product stability
      do_mul(8'd13, 8'd11);
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (product !== 16'h008F) ok = 1'b0;
      end
      chk("product_stable_143", ok, 1);

      // reset mid-operation
      dc = done_cnt;
      issue(8'hC3, 8'h5A, k);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_product", product, 0);
      chk("abort_fa_a", fa_a, 0);
      chk("abort_fa_c", fa_c, 0);
      sb.delete();
      done_exp--;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2*N + 4) @(negedge clk);
      chk("abort_no_done", done_cnt - dc, 0);
      do_mul(8'd3, 8'd5);
      chk("after_abort_3x5", product, 16'd15);

      // zero operands and boundary patterns
      do_mul(8'h00, 8'hAB);
      do_mul(8'h5A, 8'h00);
      do_mul(8'h00, 8'h00);
      do_mul(8'h01, 8'h01);
      do_mul(8'hFF, 8'h01);
      do_mul(8'h01, 8'hFF);
      do_mul(8'h80, 8'h80);
      do_mul(8'hAA, 8'h55);
      do_mul(8'hFF, 8'hFF);

      // back-to-back random operands
      for (int i = 0; i < 200; i++) begin
         do_mul(N'($urandom), N'($urandom));
      end

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
      chk("done_count", done_cnt, done_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
